// File: rtl/output_write_scheduler.sv
// Packs 8-bit ReLU results two per SRAM word and sequences the output writes.
// Optional matrix counter enabled by defining OUTPUT_WRITE_SCHEDULER_MATRIX_CNT_EN.
module output_write_scheduler #(
  parameter int                    ADDRW     = 12,
  parameter int                    DATAW     = 16,
  parameter logic [ADDRW-1:0]      BASE_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             result_valid,
  input  logic [7:0]       result_data,
  input  logic             matrix_done,
  output logic             output_sram_write_enable,
  output logic [ADDRW-1:0] output_sram_write_addresss,
  output logic [DATAW-1:0] output_sram_write_data,
  output logic             busy,
  output logic             done,
`ifdef OUTPUT_WRITE_SCHEDULER_MATRIX_CNT_EN
  output logic [ADDRW-1:0] words_written,
  output logic [7:0]       matrix_count
`else
  output logic [ADDRW-1:0] words_written
`endif
);

  typedef enum logic {EMPTY, HALF} state_e;

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDRW-1:0] wr_addr_q, wr_addr_d;
  logic [DATAW-1:0] wr_data_q, wr_data_d;
  logic [ADDRW-1:0] ptr_q, ptr_d;
  logic [ADDRW-1:0] words_q, words_d;
  logic             done_q, done_d;
  logic             issue;
  logic [DATAW-1:0] word;

  always_comb begin
    // NOTE: every signal gets a default first so no latch can be inferred.
    state_d   = state_q;
    hold_d    = hold_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    words_d   = words_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    word      = '0;

    if (start) begin
      // Start wins over any same-cycle result or boundary.
      state_d = EMPTY;
      hold_d  = 8'h00;
      ptr_d   = BASE_ADDR;
      words_d = '0;
    end else begin
      done_d = matrix_done;
      unique case (state_q)
        EMPTY: begin
          if (result_valid && matrix_done) begin
            issue = 1'b1;
            word  = {8'h00, result_data};
          end else if (result_valid) begin
            hold_d  = result_data;
            state_d = HALF;
          end
        end
        HALF: begin
          if (result_valid || matrix_done) begin
            // A same-cycle result completes the word, so no pad word follows.
            issue   = 1'b1;
            word    = {(result_valid ? result_data : 8'h00), hold_q};
            hold_d  = 8'h00;
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase

      if (issue) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = word;
        ptr_d     = ptr_q + ADDRW'(1);
        words_d   = words_q + ADDRW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= EMPTY;
      hold_q    <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ptr_q     <= BASE_ADDR;
      words_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q   <= state_d;
      hold_q    <= hold_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
      words_q   <= words_d;
      done_q    <= done_d;
    end
  end

  assign output_sram_write_enable   = wr_en_q;
  assign output_sram_write_addresss = wr_addr_q;
  assign output_sram_write_data     = wr_data_q;
  assign words_written              = words_q;
  assign done                       = done_q;
  assign busy                       = (state_q == HALF) | wr_en_q;

`ifdef OUTPUT_WRITE_SCHEDULER_MATRIX_CNT_EN
  logic [7:0] mcnt_q, mcnt_d;

  always_comb begin
    mcnt_d = mcnt_q;
    if (start)       mcnt_d = 8'h00;
    else if (done_d) mcnt_d = mcnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) mcnt_q <= 8'h00;
    else          mcnt_q <= mcnt_d;
  end

  assign matrix_count = mcnt_q;
`endif

endmodule
